gb_lcd_tx: RTL and testbench

//  Transmit side of the GB LCD pixel interface. Reads a 160x144 2-bit framebuffer through a

---
 rtl/gb_video_pkg.sv | 16 +
 rtl/gb_lcd_tick_gen.sv | 45 ++++
 rtl/gb_lcd_tx.sv | 163 ++++++++++++++++
 tb/tb_gb_lcd_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared definitions for the GB LCD video path: frame geometry, pixel type and
// the transmit FSM state encoding.
package gb_video_pkg;

    localparam int unsigned GB_H_ACTIVE = 160;
    localparam int unsigned GB_V_ACTIVE = 144;
    localparam int unsigned GB_FB_DEPTH = 23040;

    typedef logic [1:0] pixel_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/gb_lcd_tick_gen.sv
// Pixel-clock phase generator: divides clk by CLK_DIV while running and flags the
// tick boundary (pclk falling edge) and the framebuffer address slot.
module gb_lcd_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic pclk_o,
    output logic tick_fall_o,
    output logic addr_strobe_o
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_ADDR = PW'(CLK_DIV - 2);
    localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic          pclk_q;

    always_comb begin
        ph_d = '0;
        if (run_i) begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= '0;
            pclk_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            // Registered so pclk is glitch-free and held low whenever the phase is parked.
            pclk_q <= run_i && (ph_d >= PH_HALF);
        end
    end

    assign pclk_o        = pclk_q;
    assign tick_fall_o   = run_i && (ph_q == PH_LAST);
    assign addr_strobe_o = run_i && (ph_q == PH_ADDR);

endmodule

// File: rtl/gb_lcd_tx.sv
// GB LCD transmit stage: walks the frame timing, reads the framebuffer one tick
// ahead of each active pixel and drives the pclk/de/hsync/vsync/pixel stream.
module gb_lcd_tx
    import gb_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = GB_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = GB_V_ACTIVE,
    parameter int unsigned H_BLANK     = 40,
    parameter int unsigned V_BLANK     = 10,
    parameter int unsigned HSYNC_W     = 8,
    parameter int unsigned VSYNC_LINES = 1,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] fb_addr,
    input  pixel_t            fb_rdata,
    output logic              gb_pclk,
    output logic              gb_de,
    output logic              gb_hsync,
    output logic              gb_vsync,
    output pixel_t            gb_pixel,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0]     H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HSW_C   = HW'(HSYNC_W);
    localparam logic [VW-1:0]     V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_BLK_C = VW'(V_BLANK);
    localparam logic [VW-1:0]     VSYNC_C = VW'(VSYNC_LINES);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    tx_state_e         state_q;
    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic [ADDR_W-1:0] rd_q;
    logic              de_q;
    logic              hs_q;
    logic              vs_q;
    pixel_t            pix_q;
    logic              fs_q;

    logic              running;
    logic              tick_fall;
    logic              addr_strobe;
    logic              frame_last;
    logic [HW-1:0]     h_nx;
    logic [VW-1:0]     v_nx;
    logic              nx_active;
    logic              nx_hsync;
    logic              nx_vsync;

    assign running = (state_q == TX_RUN);

    gb_lcd_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (running),
        .pclk_o        (gb_pclk),
        .tick_fall_o   (tick_fall),
        .addr_strobe_o (addr_strobe)
    );

    // (h_nx, v_nx) is the tick that follows the current one; from IDLE it is
    // tick 0 of a fresh frame, so entry and restart share one load path.
    always_comb begin
        frame_last = (h_q == H_LAST) && (v_q == V_LAST);
        h_nx       = '0;
        v_nx       = '0;
        if (running) begin
            h_nx = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            v_nx = v_q;
            if (h_q == H_LAST) begin
                v_nx = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end
        end
        nx_active = (v_nx >= V_BLK_C) && (h_nx < H_ACT_C);
        nx_hsync  = (h_nx >= H_ACT_C) && ((h_nx - H_ACT_C) < HSW_C);
        nx_vsync  = (v_nx < VSYNC_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            rd_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            pix_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (enable) begin
                        state_q <= TX_RUN;
                        h_q     <= '0;
                        v_q     <= '0;
                        rd_q    <= '0;
                        de_q    <= nx_active;
                        hs_q    <= nx_hsync;
                        vs_q    <= nx_vsync;
                        pix_q   <= nx_active ? fb_rdata : '0;
                        fs_q    <= 1'b1;
                    end
                end
                TX_RUN: begin
                    // The RAM samples rd_q on this same edge, so advancing here
                    // presents the next address without disturbing the read.
                    if (addr_strobe && nx_active) begin
                        rd_q <= (rd_q == FB_LAST) ? '0 : rd_q + 1'b1;
                    end
                    if (tick_fall) begin
                        if (frame_last && !enable) begin
                            state_q <= TX_IDLE;
                            h_q     <= '0;
                            v_q     <= '0;
                            rd_q    <= '0;
                            de_q    <= 1'b0;
                            hs_q    <= 1'b0;
                            vs_q    <= 1'b0;
                            pix_q   <= '0;
                        end else begin
                            h_q   <= h_nx;
                            v_q   <= v_nx;
                            de_q  <= nx_active;
                            hs_q  <= nx_hsync;
                            vs_q  <= nx_vsync;
                            pix_q <= nx_active ? fb_rdata : '0;
                            if (frame_last) begin
                                fs_q <= 1'b1;
                                rd_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign fb_addr     = rd_q;
    assign gb_de       = de_q;
    assign gb_hsync    = hs_q;
    assign gb_vsync    = vs_q;
    assign gb_pixel    = pix_q;
    assign frame_start = fs_q;
    assign busy        = running;

endmodule

// File: tb/tb_gb_lcd_tx.sv
// Bench for gb_lcd_tx: two reduced-geometry instances (CLK_DIV 4 and 2) fed from a
// random framebuffer, checked against a tick-index reference model and a capture model.
module tb_gb_lcd_tx;

    localparam int HA    = 16;
    localparam int VA    = 12;
    localparam int HB    = 8;
    localparam int VB    = 3;
    localparam int HT    = HA + HB;
    localparam int VT    = VB + VA;
    localparam int DEPTH = HA * VA;

    function automatic int cdiv(input int d);
        return (d == 0) ? 4 : 2;
    endfunction
    function automatic int hsw(input int d);
        return (d == 0) ? 3 : 8;
    endfunction
    function automatic int vsl(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    logic clk;
    logic rst_n;
    logic en_a, en_b;

    logic [14:0] addr_a, addr_b;
    logic [1:0]  rdata_a, rdata_b;
    logic        pclk_a, de_a, hs_a, vs_a, fs_a, busy_a;
    logic        pclk_b, de_b, hs_b, vs_b, fs_b, busy_b;
    logic [1:0]  px_a, px_b;

    logic [1:0] fb [DEPTH];

    int n_assert;
    int n_fail;

    gb_lcd_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
        .HSYNC_W(3), .VSYNC_LINES(2), .CLK_DIV(4), .ADDR_W(15)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .fb_addr(addr_a), .fb_rdata(rdata_a),
        .gb_pclk(pclk_a), .gb_de(de_a), .gb_hsync(hs_a), .gb_vsync(vs_a),
        .gb_pixel(px_a), .frame_start(fs_a), .busy(busy_a)
    );

    gb_lcd_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
        .HSYNC_W(8), .VSYNC_LINES(1), .CLK_DIV(2), .ADDR_W(15)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .fb_addr(addr_b), .fb_rdata(rdata_b),
        .gb_pclk(pclk_b), .gb_de(de_b), .gb_hsync(hs_b), .gb_vsync(vs_b),
        .gb_pixel(px_b), .frame_start(fs_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read framebuffer, one clk latency
    always @(posedge clk) begin
        rdata_a <= (int'(addr_a) < DEPTH) ? fb[int'(addr_a)] : 2'b00;
        rdata_b <= (int'(addr_b) < DEPTH) ? fb[int'(addr_b)] : 2'b00;
    end

    logic [1:0] pclk_v, de_v, hs_v, vs_v, fs_v, busy_v, anz_v;
    logic [3:0] px_v;
    assign pclk_v = {pclk_b, pclk_a};
    assign de_v   = {de_b, de_a};
    assign hs_v   = {hs_b, hs_a};
    assign vs_v   = {vs_b, vs_a};
    assign fs_v   = {fs_b, fs_a};
    assign busy_v = {busy_b, busy_a};
    assign anz_v  = {|addr_b, |addr_a};
    assign px_v   = {px_b, px_a};

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int   tk     [2];
    int   clkc   [2];
    int   waddr  [2];
    int   fs_cnt [2];
    bit   inf    [2];
    bit   prev_pclk [2];
    bit   prev_busy [2];
    bit   prev_vs   [2];
    logic [1:0] cap [2][DEPTH];

    task automatic frame_done(input int d);
        int bad;
        bad = 0;
        check($sformatf("frame_ticks_%0d", d), tk[d], HT * VT);
        check($sformatf("frame_clks_%0d", d), clkc[d], HT * VT * cdiv(d));
        check($sformatf("capture_count_%0d", d), waddr[d], DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (cap[d][i] !== fb[i]) bad++;
        end
        check($sformatf("capture_data_%0d", d), bad, 0);
    endtask

    // Reference model: tick index within the frame gives (h, v) by plain division.
    always @(negedge clk) begin
        int h, v;
        logic e_de, e_hs, e_vs;
        logic [1:0] e_px, o_px;
        for (int d = 0; d < 2; d++) begin
            o_px = px_v[2*d +: 2];
            if (!rst_n) begin
                check($sformatf("reset_out_%0d", d),
                      int'({pclk_v[d], de_v[d], hs_v[d], vs_v[d], fs_v[d], busy_v[d], anz_v[d], o_px}), 0);
                inf[d]       = 1'b0;
                prev_pclk[d] = 1'b0;
                prev_busy[d] = 1'b0;
                prev_vs[d]   = 1'b0;
            end else begin
                clkc[d]++;
                if (!busy_v[d]) begin
                    check($sformatf("idle_out_%0d", d),
                          int'({pclk_v[d], de_v[d], hs_v[d], vs_v[d], fs_v[d], anz_v[d], o_px}), 0);
                end
                if (prev_busy[d] && !busy_v[d]) begin
                    if (inf[d]) frame_done(d);
                    inf[d] = 1'b0;
                end
                if (fs_v[d]) begin
                    fs_cnt[d]++;
                    if (inf[d]) frame_done(d);
                    inf[d]  = 1'b1;
                    tk[d]   = 0;
                    clkc[d] = 0;
                end
                if (vs_v[d] && !prev_vs[d]) waddr[d] = 0;
                if (pclk_v[d] && !prev_pclk[d]) begin
                    if (!inf[d]) begin
                        check($sformatf("stray_pclk_%0d", d), 1, 0);
                    end else if (tk[d] >= HT * VT) begin
                        check($sformatf("tick_overrun_%0d", d), tk[d], HT * VT - 1);
                    end else begin
                        h    = tk[d] % HT;
                        v    = tk[d] / HT;
                        e_de = (v >= VB) && (h < HA);
                        e_hs = (h >= HA) && (h < HA + hsw(d));
                        e_vs = (v < vsl(d));
                        e_px = e_de ? fb[(v - VB) * HA + h] : 2'b00;
                        check($sformatf("stream_%0d_v%0d_h%0d", d, v, h),
                              int'({de_v[d], hs_v[d], vs_v[d], o_px}),
                              int'({e_de, e_hs, e_vs, e_px}));
                        if (de_v[d]) begin
                            if (waddr[d] < DEPTH) cap[d][waddr[d]] = o_px;
                            waddr[d]++;
                        end
                        tk[d]++;
                    end
                end
                prev_pclk[d] = pclk_v[d];
                prev_busy[d] = busy_v[d];
                prev_vs[d]   = vs_v[d];
            end
        end
    end

    task automatic wait_fs(input int d, input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (fs_cnt[d] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(fs_cnt[d] >= target), 1);
    endtask

    task automatic wait_idle(input int d, input int budget, input string tag);
        int n;
        n = 0;
        while (busy_v[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy_v[d]), 0);
    endtask

    initial begin
        int f0;
        n_assert = 0;
        n_fail   = 0;
        for (int d = 0; d < 2; d++) begin
            tk[d] = 0; clkc[d] = 0; waddr[d] = 0; fs_cnt[d] = 0; inf[d] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) fb[i] = 2'($urandom_range(0, 3));
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset and a long idle period with enable low
        repeat (4) @(negedge clk);
        check("rst_outputs_a", int'({pclk_a, de_a, hs_a, vs_a, px_a, fs_a, busy_a, |addr_a}), 0);
        check("rst_outputs_b", int'({pclk_b, de_b, hs_b, vs_b, px_b, fs_b, busy_b, |addr_b}), 0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_busy", int'(busy_v), 0);
        check("idle_no_frames", fs_cnt[0] + fs_cnt[1], 0);

        // Start both; frame_start appears on the first edge after enable
        en_a = 1'b1;
        en_b = 1'b1;
        @(negedge clk);
        check("start_frame_start", int'(fs_v), 3);
        check("start_busy", int'(busy_v), 3);
        wait_fs(0, 3, 3 * HT * VT * 4 + 50, "run_two_frames_a");

        // Drop enable mid-frame: frame completes, no restart
        repeat ((VB + VA / 2) * HT * 4 + $urandom_range(0, 200)) @(negedge clk);
        en_a = 1'b0;
        f0 = fs_cnt[0];
        wait_idle(0, HT * VT * 4 + 50, "drop_reaches_idle");
        check("drop_no_restart", fs_cnt[0] - f0, 0);
        repeat (300) @(negedge clk);
        check("drop_quiet", fs_cnt[0] - f0, 0);

        // Single frame with enable chatter inside it, ending low
        f0 = fs_cnt[0];
        en_a = 1'b1;
        repeat (100) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            repeat (20) @(negedge clk);
            en_a = 1'($urandom_range(0, 1));
        end
        en_a = 1'b0;
        wait_idle(0, HT * VT * 4 + 50, "single_frame_idle");
        repeat (300) @(negedge clk);
        check("single_frame_count", fs_cnt[0] - f0, 1);

        // Reset in the middle of an active line
        en_a = 1'b1;
        wait_fs(0, fs_cnt[0] + 1, 50, "pre_reset_start");
        repeat (((VB + 6) * HT + 5) * 4 + $urandom_range(0, 40)) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_a", int'({pclk_a, de_a, hs_a, vs_a, px_a, fs_a, busy_a, |addr_a}), 0);
        check("async_reset_b", int'({pclk_b, de_b, hs_b, vs_b, px_b, fs_b, busy_b, |addr_b}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_frame_start", int'(fs_v), 3);
        check("restart_addr_a", int'(addr_a), 0);
        check("restart_addr_b", int'(addr_b), 0);
        wait_fs(0, fs_cnt[0] + 1, HT * VT * 4 + 50, "restart_full_frame_a");

        en_a = 1'b0;
        en_b = 1'b0;
        wait_idle(0, HT * VT * 4 + 50, "final_idle_a");
        wait_idle(1, HT * VT * 2 + 50, "final_idle_b");
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
